// File: rtl/apb_interconnect.sv
// apb_interconnect: one-master, NSLAVES-slave APB3 interconnect for the debugger bus.
// Decodes PADDR against base/mask windows, fans the bus out, muxes responses back,
// answers unmapped accesses with an error, aborts slaves that stall past TIMEOUT,
// and keeps a small error log (saturating count plus last faulting address).
module apb_interconnect #(
  parameter int unsigned               NSLAVES = 4,
  parameter int unsigned               AW      = 5,
  parameter int unsigned               DW      = 8,
  parameter logic [NSLAVES*AW-1:0]     BASE    = {5'h18, 5'h10, 5'h01, 5'h00},
  parameter logic [NSLAVES*AW-1:0]     MASK    = {5'h18, 5'h18, 5'h1F, 5'h1F},
  parameter int unsigned               TIMEOUT = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic [AW-1:0]         PADDR,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [DW-1:0]         PWDATA,
  output logic [DW-1:0]         PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic [NSLAVES-1:0]    S_PSEL,
  output logic                  S_PENABLE,
  output logic [AW-1:0]         S_PADDR,
  output logic                  S_PWRITE,
  output logic [DW-1:0]         S_PWDATA,
  input  logic [NSLAVES*DW-1:0] S_PRDATA,
  input  logic [NSLAVES-1:0]    S_PREADY,
  input  logic [NSLAVES-1:0]    S_PSLVERR,
  input  logic                  ERR_CLR,
  output logic [7:0]            ERR_COUNT,
  output logic [AW-1:0]         ERR_ADDR
);

  localparam int unsigned IW      = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
  // Wait count at which a still-stalled slave is aborted.
  localparam logic [7:0]  TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, ABORT} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            unmapped_q, unmapped_d;
  logic [7:0]      wc_q, wc_d;
  logic [7:0]      err_count_q, err_count_d;
  logic [AW-1:0]   err_addr_q, err_addr_d;

  logic [IW-1:0]   dec_idx;
  logic            dec_hit;
  logic            setup;
  logic            timeout_hit;
  logic            err_event;

  function automatic logic [NSLAVES-1:0] onehot(input logic [IW-1:0] idx);
    logic [NSLAVES-1:0] v;
    for (int i = 0; i < NSLAVES; i++) v[i] = (idx == IW'(i));
    return v;
  endfunction

  // Broadcast side of the bus follows the master with zero latency.
  assign S_PENABLE = PENABLE;
  assign S_PADDR   = PADDR;
  assign S_PWRITE  = PWRITE;
  assign S_PWDATA  = PWDATA;

  assign setup       = PSEL & ~PENABLE;
  assign timeout_hit = (TIMEOUT != 0) && (wc_q == TO_LAST);

  // Address decode: scan high to low so the lowest matching window wins.
  always_comb begin
    dec_hit = 1'b0;
    dec_idx = '0;
    for (int i = NSLAVES - 1; i >= 0; i--) begin
      if ((PADDR & MASK[i*AW +: AW]) == BASE[i*AW +: AW]) begin
        dec_hit = 1'b1;
        dec_idx = IW'(i);
      end
    end
  end

  // Transfer FSM next state and master/slave select outputs.
  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path
    // through the case can leave one unassigned and infer a latch.
    state_d    = state_q;
    idx_d      = idx_q;
    unmapped_d = unmapped_q;
    wc_d       = wc_q;
    S_PSEL     = '0;
    PREADY     = 1'b0;
    PSLVERR    = 1'b0;
    PRDATA     = '0;
    if (!PRESET) begin
      case (state_q)
        IDLE, ABORT: begin
          if (setup) begin
            S_PSEL     = dec_hit ? onehot(dec_idx) : '0;
            idx_d      = dec_idx;
            unmapped_d = ~dec_hit;
            wc_d       = '0;
            state_d    = ACCESS;
          end else if (state_q == ABORT && !PSEL) begin
            state_d = IDLE;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            state_d = IDLE;
          end else if (unmapped_q) begin
            PREADY  = 1'b1;
            PSLVERR = 1'b1;
            state_d = IDLE;
          end else begin
            S_PSEL = onehot(idx_q);
            if (S_PREADY[idx_q]) begin
              PREADY  = 1'b1;
              PSLVERR = S_PSLVERR[idx_q];
              PRDATA  = S_PRDATA[int'(idx_q)*DW +: DW];
              state_d = IDLE;
            end else if (timeout_hit) begin
              PREADY  = 1'b1;
              PSLVERR = 1'b1;
              state_d = ABORT;
            end else if (wc_q != 8'hFF) begin
              wc_d = wc_q + 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Error log next state: any completion carrying PSLVERR counts.
  always_comb begin
    err_event   = PREADY & PSLVERR;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (ERR_CLR)
      err_count_d = err_event ? 8'd1 : 8'd0;
    else if (err_event && err_count_q != 8'hFF)
      err_count_d = err_count_q + 8'd1;
    if (err_event)
      err_addr_d = PADDR;
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge PCLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before this edge.
    if (PRESET) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      unmapped_q  <= 1'b0;
      wc_q        <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      unmapped_q  <= unmapped_d;
      wc_q        <= wc_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign ERR_COUNT = err_count_q;
  assign ERR_ADDR  = err_addr_q;

endmodule
